// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file request encoder: sizes, FSM encoding
// and small helpers.
package regfile_pkg;

    localparam int NREG = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [3:0] popcount8(input logic [NREG-1:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < NREG; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    function automatic logic [NREG-1:0] onehot8(input logic [IDXW-1:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/rot_prienc8.sv
// Combinational priority encoder that starts its search at ptr and wraps 7 -> 0.
module rot_prienc8
    import regfile_pkg::*;
(
    input  logic [NREG-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [14:0]     w_dbl;
    logic [7:0]      w_rot;
    logic [IDXW-1:0] w_off;

    // w_rot[j] is req[(ptr + j) mod 8], so bit 0 is the highest-priority position.
    assign w_dbl = {req[6:0], req};
    assign w_rot = w_dbl[ptr +: 8];

    always_comb begin
        found = 1'b0;
        w_off = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (w_rot[j]) begin
                found = 1'b1;
                w_off = 3'(j);
            end
        end
    end

    assign idx = ptr + w_off;

endmodule

// File: rtl/rr_encode8to3.sv
// 8-to-3 request encoder/arbiter: registered grant with valid/ready handshake,
// round-robin or fixed priority, plus a registered request population count.
module rr_encode8to3
    import regfile_pkg::*;
#(
    parameter int RR_MODE      = 1,
    parameter int HOLD_ON_DROP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREG-1:0] req,
    input  logic            grant_ready,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic [NREG-1:0] grant_onehot,
    output logic [3:0]      busy_cnt
);

    state_t          r_state;
    logic            r_valid;
    logic [IDXW-1:0] r_idx;
    logic [NREG-1:0] r_onehot;
    logic [3:0]      r_busy;
    logic [IDXW-1:0] r_ptr;

    logic            w_accept;
    logic            w_keep;
    logic            w_found;
    logic [IDXW-1:0] w_idx;
    logic [IDXW-1:0] w_ptr_sel;

    assign w_accept = r_valid && grant_ready;

    // On accept the search already starts past the served index, so a back-to-back
    // grant sees the just-served requester as lowest priority.
    assign w_ptr_sel = (w_accept && (RR_MODE != 0)) ? r_idx + 3'd1 : r_ptr;

    assign w_keep = r_valid && !w_accept && ((HOLD_ON_DROP != 0) || req[r_idx]);

    rot_prienc8 u_enc (
        .req   (req),
        .ptr   (w_ptr_sel),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_onehot <= '0;
            r_busy   <= 4'd0;
            r_ptr    <= '0;
        end else begin
            r_busy <= popcount8(req);
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state  <= GRANT;
                        r_valid  <= 1'b1;
                        r_idx    <= w_idx;
                        r_onehot <= onehot8(w_idx);
                    end
                end
                GRANT: begin
                    if (w_accept && (RR_MODE != 0)) begin
                        r_ptr <= w_ptr_sel;
                    end
                    if (!w_keep) begin
                        if (w_found) begin
                            r_idx    <= w_idx;
                            r_onehot <= onehot8(w_idx);
                        end else begin
                            r_state  <= IDLE;
                            r_valid  <= 1'b0;
                            r_onehot <= '0;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_valid  <= 1'b0;
                    r_onehot <= '0;
                end
            endcase
        end
    end

    assign grant_valid  = r_valid;
    assign grant_idx    = r_idx;
    assign grant_onehot = r_onehot;
    assign busy_cnt     = r_busy;

endmodule

// File: tb/tb_rr_encode8to3.sv
// Scoreboard bench for rr_encode8to3: three configurations share one stimulus
// stream and are compared each cycle against a behavioural arbitration model.
module tb_rr_encode8to3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic       grant_ready = 1'b0;

    logic [2:0]      v;
    logic [2:0][2:0] ix;
    logic [2:0][7:0] oh;
    logic [2:0][3:0] bc;

    // index 0: round-robin + hold, 1: fixed priority + hold, 2: round-robin + withdraw
    rr_encode8to3 #(.RR_MODE(1), .HOLD_ON_DROP(1)) dut_rr (
        .clk(clk), .reset(reset), .req(req), .grant_ready(grant_ready),
        .grant_valid(v[0]), .grant_idx(ix[0]), .grant_onehot(oh[0]), .busy_cnt(bc[0]));
    rr_encode8to3 #(.RR_MODE(0), .HOLD_ON_DROP(1)) dut_fp (
        .clk(clk), .reset(reset), .req(req), .grant_ready(grant_ready),
        .grant_valid(v[1]), .grant_idx(ix[1]), .grant_onehot(oh[1]), .busy_cnt(bc[1]));
    rr_encode8to3 #(.RR_MODE(1), .HOLD_ON_DROP(0)) dut_nd (
        .clk(clk), .reset(reset), .req(req), .grant_ready(grant_ready),
        .grant_valid(v[2]), .grant_idx(ix[2]), .grant_onehot(oh[2]), .busy_cnt(bc[2]));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
        logic [3:0] busy;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    exp3_t sb[$];
    exp3_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    logic       m_v[3];
    logic [2:0] m_idx[3];
    logic [2:0] m_ptr[3];
    logic [3:0] m_busy[3];

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    // First requester found when scanning p, p+1, ... p+7 (mod 8).
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        int b;
        logic [2:0] res;
        res = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            b = (int'(p) + k) % 8;
            if (r[b]) res = 3'(b);
        end
        return res;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_v[d] = 1'b0; m_idx[d] = 3'd0; m_ptr[d] = 3'd0; m_busy[d] = 4'd0;
        end
    endtask

    task automatic model_step(input logic [7:0] r, input logic rd);
        logic acc, rr, hold;
        for (int d = 0; d < 3; d++) begin
            acc  = m_v[d] && rd;
            rr   = (d != 1);
            hold = (d != 2);
            if (acc && rr) m_ptr[d] = m_idx[d] + 3'd1;
            if (m_v[d] && !acc && (hold || r[m_idx[d]])) begin
                m_v[d] = 1'b1;
            end else if (r != 8'h00) begin
                m_v[d]   = 1'b1;
                m_idx[d] = pick(r, m_ptr[d]);
            end else begin
                m_v[d] = 1'b0;
            end
            m_busy[d] = 4'($countones(r));
        end
    endtask

    // Called at posedge+1: records what the DUTs must show this cycle, then drives
    // the inputs for the coming edge and advances the model across it.
    task automatic cycle(input logic [7:0] r, input logic rd);
        exp3_t e;
        for (int d = 0; d < 3; d++) begin
            e[d].v    = m_v[d];
            e[d].idx  = m_idx[d];
            e[d].busy = m_busy[d];
        end
        sb.push_back(e);
        req = r;
        grant_ready = rd;
        model_step(r, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        #1;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid",  d, int'(v[d]),  0);
            chk("rst_onehot", d, int'(oh[d]), 0);
            chk("rst_busy",   d, int'(bc[d]), 0);
            chk("rst_idx",    d, int'(ix[d]), 0);
        end
        req = 8'h00;
        grant_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (!reset && sb.size() > 0) begin
            mon_e = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                chk("valid",  d, int'(v[d]),  int'(mon_e[d].v));
                chk("onehot", d, int'(oh[d]), mon_e[d].v ? (1 << mon_e[d].idx) : 0);
                if (mon_e[d].v) chk("idx", d, int'(ix[d]), int'(mon_e[d].idx));
                chk("busy",   d, int'(bc[d]), int'(mon_e[d].busy));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       rd;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("init_valid",  d, int'(v[d]),  0);
            chk("init_onehot", d, int'(oh[d]), 0);
            chk("init_busy",   d, int'(bc[d]), 0);
            chk("init_idx",    d, int'(ix[d]), 0);
        end
        reset = 1'b0;

        // Grant on index 5 aborted by an asynchronous reset, then restart with req=01.
        cycle(8'h20, 1'b0);
        cycle(8'h20, 1'b0);
        mid_reset();
        cycle(8'h01, 1'b1);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b0);

        // req=24 held under backpressure, then accepted; next grant moves to 5.
        mid_reset();
        cycle(8'h24, 1'b0);
        repeat (3) cycle(8'h24, 1'b0);
        cycle(8'h24, 1'b1);
        cycle(8'h24, 1'b0);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b0);

        // All requesters with continuous ready.
        mid_reset();
        repeat (11) cycle(8'hFF, 1'b1);
        cycle(8'h00, 1'b1);

        // Two requesters at opposite ends.
        mid_reset();
        repeat (8) cycle(8'h81, 1'b1);
        cycle(8'h00, 1'b1);

        // Request withdrawn while its grant waits for ready.
        mid_reset();
        cycle(8'h08, 1'b0);
        repeat (3) cycle(8'h00, 1'b0);
        cycle(8'h00, 1'b1);
        repeat (2) cycle(8'h00, 1'b0);

        // Accept index 7 with 0 also requesting, then a sole requester re-granted.
        mid_reset();
        cycle(8'h80, 1'b0);
        cycle(8'h81, 1'b1);
        cycle(8'h01, 1'b1);
        cycle(8'h01, 1'b1);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b0);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 7))
                0:       r = 8'h00;
                1:       r = 8'h01 << $urandom_range(0, 7);
                2:       r = 8'hFF;
                default: r = 8'($urandom);
            endcase
            rd = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) mid_reset();
            cycle(r, rd);
        end
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b0);

        @(negedge clk);
        #1;
        chk("sb_drain", 0, sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_encode8to3.md
Name: rr_encode8to3

Overview:
- Sequential 8-to-3 request encoder and arbiter, the read-back counterpart of the register file's 3-to-8 write-load decoder.
- Collects up to 8 one-per-register request lines, picks one each grant, and presents it as a 3-bit index plus a one-hot vector.
- Grant handshake is valid/ready, with round-robin or fixed priority.
- Sits between register-level requesters (for example, dirty/ready flags per register) and a single shared read or service port.

Parameters:
- RR_MODE, 1, 1 = round-robin priority; 0 = fixed priority (bit 0 highest).
- HOLD_ON_DROP, 1, 1 = an issued grant is held until accepted even if its request deasserts; 0 = grant is withdrawn when its request drops.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  8  request lines; bit i requests register i.
- grant_ready  in  1  consumer accepts the current grant when grant_valid && grant_ready.
- grant_valid  out  1  a grant is presented.
- grant_idx  out  3  binary index of the granted request.
- grant_onehot  out  8  one-hot form of grant_idx; all zeros when grant_valid = 0.
- busy_cnt  out  4  population count of req, registered (0..8).

Behaviour:
- Reset: the only reset is asynchronous, active-high `reset`. It forces:
  - state = IDLE
  - grant_valid = 0, grant_idx = 3'd0, grant_onehot = 8'h00
  - busy_cnt = 4'd0
  - round-robin pointer ptr = 3'd0
- Reset mid-grant aborts the grant with no acceptance; the outputs above apply immediately, without waiting for a clock edge.
- State machine, two states:
  - IDLE: on an edge with req != 0, go to GRANT. grant_valid = 1 and grant_idx = the selected index, both registered.
  - GRANT, grant_valid && grant_ready on an edge (accept): update ptr (see below). If req at that edge still has any bit set, recompute and stay in GRANT with the new index (back-to-back, no bubble). Otherwise go to IDLE, grant_valid = 0.
  - GRANT, grant_valid && !grant_ready: hold grant_idx and grant_onehot stable.
  - GRANT with HOLD_ON_DROP = 0: if req[grant_idx] = 0 at an edge, re-select from the current req, or go to IDLE if req = 0.
- Latency: req asserted in cycle N gives grant_valid in cycle N+1. Nothing passes combinationally from req to the outputs.
- Selection:
  - RR_MODE = 1: the first set bit scanning ptr, ptr+1, …, ptr+7, modulo 8 (wraps 7 → 0).
  - RR_MODE = 0: the lowest set bit.
- Pointer update on accept:
  - RR_MODE = 1: ptr = grant_idx + 1, 3-bit modular, so 7 → 0.
  - RR_MODE = 0: ptr is unused and stays 0.
- Simultaneous accept and new request: the new request is evaluated with the updated ptr. The just-served index becomes lowest priority. It is re-granted only if it is the sole requester.
- req = 8'hFF under continuous ready in RR_MODE = 1 gives indices 0, 1, 2, …, 7, 0, … on successive cycles.
- grant_onehot always equals 1 << grant_idx while grant_valid = 1.
- busy_cnt is registered each cycle as the count of req bits. Width rule: a 4-bit sum of eight 1-bit terms, no overflow.
- grant_ready while grant_valid = 0 is ignored.

Decomposition:
- Shared package `regfile_pkg` holds:
  - NREG = 8, IDXW = 3
  - the state encoding: IDLE = 1'b0, GRANT = 1'b1
- Natural sub-module `rot_prienc8`: combinational rotate-by-ptr priority encoder. Inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0]. It is instantiated once in the top module.

Test Plan:
- Reset asserted mid-grant (state GRANT, idx = 5) asynchronously between edges → grant_valid, grant_onehot and busy_cnt go to 0 immediately; after release with req = 8'h01, grant_idx = 0 one cycle later.
- req = 8'h24, grant_ready = 0 for 3 cycles, then 1 → grant_idx = 2 held stable for all 4 cycles. Next cycle grant_idx = 5, grant_onehot = 8'h20.
- RR_MODE = 1, req = 8'hFF, grant_ready = 1 continuously → idx sequence 0, 1, …, 7, 0 with no idle cycle; busy_cnt = 8.
- RR_MODE = 0, req = 8'h81, grant_ready = 1 → idx 0 on every grant, never 7 (starvation expected).
- HOLD_ON_DROP = 1: grant idx = 3, then req drops to 0 with ready = 0 → grant stays valid with idx 3 until accepted, then IDLE.
- HOLD_ON_DROP = 0: the same stimulus → grant_valid = 0 the cycle after the drop.
- Accept idx = 7 with req = 8'h81 → next grant_idx = 0 (ptr wrap to 0). Then accept with only req = 8'h01 → re-grant idx 0 back-to-back.
